param_sync_fifo: RTL
====================

PARAM_SYNC_FIFO -- requirements
Module: param_sync_fifo

Interface
REQ-001 Parameter DATA_W, default 8: width of each data word in bits, legal range 1..256.
REQ-002 Parameter DEPTH, default 16: number of entries, a power of two, legal range 4..1024.
REQ-003 Parameter AF_THRESH, default DEPTH-2: almost_full asserts when count >= AF_THRESH.
REQ-004 Parameter AE_THRESH, default 2: almost_empty asserts when count <= AE_THRESH.
REQ-005 The block SHALL use one clock; reset is synchronous and active-high.
REQ-006 clk  input  1  sole clock; all state updates on its rising edge.
REQ-007 rst  input  1  synchronous, active-high reset.
REQ-008 wr_en  input  1  write request.
REQ-009 wr_data  input  DATA_W  write word.
REQ-010 rd_en  input  1  read request.
REQ-011 rd_data  output  DATA_W  read word, registered.
REQ-012 rd_valid  output  1  rd_data holds a word popped in the previous cycle.
REQ-013 full, empty  output  1 each  occupancy flags, registered.
REQ-014 almost_full, almost_empty  output  1 each  threshold flags, registered.
REQ-015 count  output  $clog2(DEPTH+1)  current occupancy.
REQ-016 overflow, underflow  output  1 each  error flags.

Function
REQ-017 Write accepted iff wr_en && (!full || rd_en); the accepted word is stored at wr_ptr, which then advances modulo DEPTH.
REQ-018 Read accepted iff rd_en && !empty; head word appears on rd_data with rd_valid=1 on the next cycle (latency 1).
REQ-019 rd_data SHALL hold its last value when no read is accepted; rd_valid=0 in that cycle.
REQ-020 Pointers carry one extra wrap bit; full = (addresses equal, wrap bits differ); empty = pointers equal.
REQ-021 count: +1 on write only, -1 on read only, unchanged on both or neither; it never exceeds DEPTH and never goes below 0.
REQ-022 When full, a simultaneous read and write are both accepted; full stays 1.
REQ-023 When empty, a simultaneous read and write: the read is rejected (underflow), the write is accepted, count becomes 1.
REQ-024 overflow event = wr_en && full && !rd_en; underflow event = rd_en && empty.
REQ-025 A rejected access SHALL NOT alter pointers, count or memory.
REQ-026 All flags SHALL reflect post-update occupancy in the cycle after the access (registered, no combinational paths from inputs to outputs).

Reset
REQ-027 While rst=1 at a clk edge: pointers=0, count=0, empty=1, almost_empty=1, full=0, almost_full=0, rd_valid=0, rd_data=0, overflow=0, underflow=0.
REQ-028 Reset mid-operation SHALL discard all contents; memory array contents need not be cleared.
REQ-029 Accesses presented in the reset cycle SHALL be ignored.

Configuration
REQ-030 Macro FIFO_STICKY_ERR_EN defined: overflow and underflow latch high on their event and clear only on rst.
REQ-031 Macro FIFO_STICKY_ERR_EN undefined: overflow and underflow are single-cycle pulses, registered, one cycle after the event.

Structure
REQ-032 Shared package fifo_pkg SHALL hold default parameter constants and a function computing count width.
REQ-033 The storage array SHALL be a sub-module fifo_mem (1 write port, 1 registered read port, parameterised DATA_W/DEPTH).
REQ-034 Parameter legality (power-of-two DEPTH, AE_THRESH < AF_THRESH <= DEPTH) SHALL be checked at elaboration.

Verification
REQ-035 Reset, then write 0x01..0x10 (DEPTH=16) -> full=1 after the 16th write, count=16, almost_full=1 from count=14.
REQ-036 From full, read 16 times -> rd_data 0x01..0x10 in order, each one cycle after rd_en; empty=1 at the end.
REQ-037 Full, simultaneous wr 0xAA and rd -> the oldest word is read, count stays 16, no overflow.
REQ-038 Empty, rd_en=1 with wr_en=1 data 0x55 -> underflow event, count=1, next read returns 0x55.
REQ-039 Full, wr_en only -> overflow is a 1-cycle pulse (macro off) or stays high until rst (macro on); contents unchanged.
REQ-040 Write 5 words, assert rst for one cycle -> empty=1, count=0, rd_valid=0; a subsequent read produces underflow.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared defaults and helpers for the synchronous FIFO.
package fifo_pkg;

    localparam int unsigned DEF_DATA_W    = 8;
    localparam int unsigned DEF_DEPTH     = 16;
    localparam int unsigned DEF_AE_THRESH = 2;

    // Width needed to hold an occupancy of 0..depth inclusive.
    function automatic int unsigned fifo_count_w(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// Storage array for the FIFO: one write port, one registered read port.
// The read register returns the pre-write contents when both ports hit the
// same address in one cycle (needed when the FIFO is full and reads+writes).
module fifo_mem #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 16,
    localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rd_data_q;

    // Array write; contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    // Read register: loads on an accepted read, otherwise holds.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_q <= '0;
        end else if (rd_en) begin
            rd_data_q <= mem_q[rd_addr];
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/param_sync_fifo.sv
// Parameterised single-clock FIFO with registered status flags.
// Optional macro FIFO_STICKY_ERR_EN: overflow/underflow latch until reset
// instead of pulsing for one cycle.
module param_sync_fifo
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_W    = DEF_DATA_W,
    parameter int unsigned DEPTH     = DEF_DEPTH,
    parameter int unsigned AF_THRESH = DEPTH - 2,
    parameter int unsigned AE_THRESH = DEF_AE_THRESH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [DATA_W-1:0]          wr_data,
    input  logic                       rd_en,
    output logic [DATA_W-1:0]          rd_data,
    output logic                       rd_valid,
    output logic                       full,
    output logic                       empty,
    output logic                       almost_full,
    output logic                       almost_empty,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int unsigned ADDR_W = $clog2(DEPTH);
    localparam int unsigned PTR_W  = ADDR_W + 1;
    localparam int unsigned CNT_W  = fifo_count_w(DEPTH);

    localparam logic [CNT_W-1:0] AF_LVL = CNT_W'(AF_THRESH);
    localparam logic [CNT_W-1:0] AE_LVL = CNT_W'(AE_THRESH);

    // Elaboration-time legality checks.
    if ((DEPTH & (DEPTH - 1)) != 0 || DEPTH < 4 || DEPTH > 1024) begin : g_bad_depth
        $error("param_sync_fifo: DEPTH must be a power of two in 4..1024");
    end
    if (DATA_W < 1 || DATA_W > 256) begin : g_bad_width
        $error("param_sync_fifo: DATA_W must be in 1..256");
    end
    if (!(AE_THRESH < AF_THRESH && AF_THRESH <= DEPTH)) begin : g_bad_thresh
        $error("param_sync_fifo: need AE_THRESH < AF_THRESH <= DEPTH");
    end

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             afull_q, afull_d;
    logic             aempty_q, aempty_d;
    logic             rd_valid_q;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;

    logic wr_acc, rd_acc;
    logic ovf_evt, unf_evt;

    // Access acceptance and error events, decided from registered flags only.
    always_comb begin
        rd_acc  = rd_en && !empty_q;
        // Writing into a full FIFO is fine when a read frees the head slot.
        wr_acc  = wr_en && (!full_q || rd_en);
        ovf_evt = wr_en && full_q && !rd_en;
        unf_evt = rd_en && empty_q;
    end

    // Next-state pointers, occupancy and flags (post-update view).
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (rd_acc) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        unique case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        full_d   = (wr_ptr_d[ADDR_W-1:0] == rd_ptr_d[ADDR_W-1:0])
                   && (wr_ptr_d[ADDR_W] != rd_ptr_d[ADDR_W]);
        empty_d  = (wr_ptr_d == rd_ptr_d);
        afull_d  = (count_d >= AF_LVL);
        aempty_d = (count_d <= AE_LVL);
`ifdef FIFO_STICKY_ERR_EN
        ovf_d = ovf_q || ovf_evt;
        unf_d = unf_q || unf_evt;
`else
        ovf_d = ovf_evt;
        unf_d = unf_evt;
`endif
    end

    // State register with synchronous reset; accesses in the reset cycle are dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            afull_q    <= 1'b0;
            aempty_q   <= 1'b1;
            rd_valid_q <= 1'b0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            full_q     <= full_d;
            empty_q    <= empty_d;
            afull_q    <= afull_d;
            aempty_q   <= aempty_d;
            rd_valid_q <= rd_acc;
            ovf_q      <= ovf_d;
            unf_q      <= unf_d;
        end
    end

    fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_acc && !rst),
        .wr_addr (wr_ptr_q[ADDR_W-1:0]),
        .wr_data (wr_data),
        .rd_en   (rd_acc && !rst),
        .rd_addr (rd_ptr_q[ADDR_W-1:0]),
        .rd_data (rd_data)
    );

    assign rd_valid     = rd_valid_q;
    assign full         = full_q;
    assign empty        = empty_q;
    assign almost_full  = afull_q;
    assign almost_empty = aempty_q;
    assign count        = count_q;
    assign overflow     = ovf_q;
    assign underflow    = unf_q;

endmodule
